// File: rtl/addsub_accum_ctrl.sv
// addsub_accum_ctrl: sequences a job of signed add/sub operands into a running accumulator with sticky overflow.
// Optional ACCUM_SAT_EN macro saturates the accumulator on step overflow instead of wrapping.
module addsub_accum_ctrl #(
  parameter int WIDTH   = 4,
  parameter int MAX_OPS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       num_ops,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sub,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic [3:0]       ops_left
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] s, nxt;
  logic [3:0] n;
  logic step_ovf, xfer;
  assign n = num_ops > 4'(MAX_OPS) ? 4'(MAX_OPS) : num_ops;
  assign in_ready = state == ACCUM;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    xfer = in_ready && in_valid;
    s = in_sub ? result - in_data : result + in_data;
    step_ovf = (in_sub ? result[WIDTH-1] != in_data[WIDTH-1] : result[WIDTH-1] == in_data[WIDTH-1])
               && s[WIDTH-1] != result[WIDTH-1];
`ifdef ACCUM_SAT_EN
    // on overflow the true sum always carries the accumulator's sign
    nxt = step_ovf ? (result[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}) : s;
`else
    nxt = s;
`endif
    state_nx = state == IDLE  ? (start ? (n == 4'd0 ? DONE : ACCUM) : IDLE) :
               state == ACCUM ? (xfer && ops_left == 4'd1 ? DONE : ACCUM) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      result <= '0;
      ovf <= 1'b0;
      ops_left <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        result <= '0;
        ovf <= 1'b0;
        ops_left <= n;
      end else if (xfer) begin
        result <= nxt;
        ovf <= ovf | step_ovf;
        ops_left <= ops_left - 4'd1;
      end
    end
endmodule

// File: tb/tb_addsub_accum_ctrl.sv
// tb_addsub_accum_ctrl: randomized scoreboard bench for addsub_accum_ctrl.
module tb_addsub_accum_ctrl;
  localparam int W = 4, MX = 8, HI = 7, LO = -8;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0, in_sub = 0;
  logic [3:0] num_ops = 0;
  logic [W-1:0] in_data = 0;
  logic in_ready, busy, done, ovf;
  logic [W-1:0] result;
  logic [3:0] ops_left;
  int total = 0, bad = 0;
  typedef struct {int res; bit o;} exp_t;
  exp_t q[$];
  int m_res = 0;
  bit m_ovf = 0, prev_done = 0;
  int jd[$];
  bit js[$];

  always #5 clk = ~clk;

  addsub_accum_ctrl #(.WIDTH(W), .MAX_OPS(MX)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_ops(num_ops), .in_valid(in_valid),
    .in_data(in_data), .in_sub(in_sub), .in_ready(in_ready), .busy(busy), .done(done),
    .result(result), .ovf(ovf), .ops_left(ops_left));

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: exact integer arithmetic, then wrap or clamp into the signed range
  function automatic int step(int r, int d, bit sub, output bit o);
    int t = sub ? r - d : r + d;
    o = (t > HI) || (t < LO);
`ifdef ACCUM_SAT_EN
    return t > HI ? HI : (t < LO ? LO : t);
`else
    return (((t - LO) % 16) + 16) % 16 + LO;
`endif
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (prev_done) begin
        total++; bad++;
        $display("FAIL done_width: got 2+ cycles want 1");
      end
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: got done want none at %0t", $time);
      end else begin
        e = q.pop_front();
        chk("result", int'($signed(result)), e.res);
        chk("ovf", int'(ovf), int'(e.o));
      end
    end
    prev_done = done;
  end

  task automatic do_start(int n);
    int nc = n > MX ? MX : n;
    m_res = 0; m_ovf = 0;
    if (nc == 0) q.push_back('{0, 0});
    start = 1; num_ops = n[3:0];
    @(posedge clk); #1;
    start = 0;
    chk("ops_left_start", int'(ops_left), nc);
    chk("busy_start", int'(busy), 1);
    if (nc == 0) begin
      @(posedge clk); #1;
      chk("idle_after_zero", int'(busy), 0);
    end
  endtask

  task automatic send_op(int d, bit sub, int gap, bit last, bit poke, int left);
    bit o, acc = 0;
    int k = 0;
    int g = gap < 0 ? $urandom_range(0, 2) : gap;
    for (int i = 0; i < g; i++) begin
      in_valid = 0;
      if (poke) begin start = 1; num_ops = 4'($urandom_range(1, 15)); end
      @(negedge clk);
      chk("gap_ready", int'(in_ready), 1);
      chk("gap_ops_left", int'(ops_left), left);
      @(posedge clk); #1;
      start = 0;
    end
    m_res = step(m_res, d, sub, o);
    m_ovf |= o;
    if (last) q.push_back('{m_res, m_ovf});
    in_valid = 1; in_data = d[W-1:0]; in_sub = sub;
    while (!acc && k < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      k++;
    end
    if (!acc) begin
      total++; bad++;
      $display("FAIL accept_timeout: got no accept want accept");
    end
    in_valid = 0; in_data = 4'($urandom);
    chk("ops_left_step", int'(ops_left), left - 1);
    if (last) begin
      @(negedge clk);
      chk("done_latency", int'(done), 1);
      @(posedge clk); #1;
      chk("idle_busy", int'(busy), 0);
    end
  endtask

  task automatic job(int n, int gap, bit poke);
    int nc = n > MX ? MX : n;
    do_start(n);
    for (int i = 0; i < nc; i++)
      send_op(jd[i], js[i], gap, i == nc - 1, poke, nc - i);
  endtask

  initial begin
    #1;
    chk("rst_result", int'(result), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(in_ready), 0);
    chk("rst_ops_left", int'(ops_left), 0);
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
    jd = '{3, 2};   js = '{0, 0};    job(2, 0, 0);
    jd = '{7, 1};   js = '{0, 0};    job(2, 0, 0);
    jd = '{-8};     js = '{1};       job(1, 0, 0);
    jd = '{7, 1, -1}; js = '{0, 0, 0}; job(3, 2, 0);
    job(0, 0, 0);
    jd.delete(); js.delete();
    for (int i = 0; i < MX; i++) begin jd.push_back(i - 3); js.push_back(i[0]); end
    job(12, 0, 0);
    // operands offered outside ACCUM must be ignored and results must hold
    in_valid = 1; in_data = 4'd5; in_sub = 0;
    repeat (2) begin
      @(negedge clk);
      chk("idle_ready", int'(in_ready), 0);
      chk("idle_hold", int'($signed(result)), m_res);
    end
    @(posedge clk); #1 in_valid = 0;
    jd = '{1, 2, 3}; js = '{0, 0, 0};
    do_start(3);
    send_op(1, 0, 1, 0, 1, 3);
    rst_n = 0; #1;
    chk("abort_result", int'(result), 0);
    chk("abort_ops_left", int'(ops_left), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_ready", int'(in_ready), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
    jd = '{-4, 5}; js = '{1, 0}; job(2, 1, 1);
    for (int t = 0; t < 25; t++) begin
      int n = $urandom_range(0, 12);
      jd.delete(); js.delete();
      for (int i = 0; i < MX; i++) begin
        jd.push_back($urandom_range(0, 15) - 8);
        js.push_back(1'($urandom));
      end
      job(n, -1, 1'($urandom));
    end
    repeat (3) @(posedge clk);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
